// File: rtl/dbg_master.sv
// Debug-port master: queues host register commands and plays them one at a time
// onto the debug controller port (req/ack for REQ_ADDR writes, fixed-latency reads).
module dbg_master #(
  parameter int unsigned ADDR_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned REQ_ADDR     = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  wr_en,
  output logic                  req,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  ack
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int unsigned TMO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  typedef struct packed {
    logic                  rnw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_ACK  = 2'd2,
    READ_WAIT = 2'd3
  } state_t;

  cmd_t             fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] write_data_nxt;
  logic                  wr_en_nxt;
  logic                  req_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_data_nxt;
  logic                  err_nxt;
  logic                  set_err;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [TMO_W-1:0]      tmo_cnt_nxt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [LAT_W-1:0]      lat_cnt_nxt;

  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = !empty || (state != IDLE);

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{rnw: cmd_rnw, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      write_data <= '0;
      wr_en      <= 1'b0;
      req        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      err        <= 1'b0;
      tmo_cnt    <= '0;
      lat_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      write_data <= write_data_nxt;
      wr_en      <= wr_en_nxt;
      req        <= req_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      err        <= err_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      lat_cnt    <= lat_cnt_nxt;
    end
  end

  // Dispatch, handshake and read-capture sequencing.
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    write_data_nxt = write_data;
    wr_en_nxt      = wr_en;
    req_nxt        = req;
    rsp_data_nxt   = rsp_data;
    tmo_cnt_nxt    = tmo_cnt;
    lat_cnt_nxt    = lat_cnt;
    set_err        = 1'b0;
    pop            = 1'b0;
    rsp_valid_nxt  = rsp_valid && !rsp_ready;

    case (state)
      IDLE: begin
        // A read needs the response slot free; ack low enforces the four-phase return.
        if (!empty && !ack && !(head.rnw && rsp_valid)) begin
          pop            = 1'b1;
          addr_nxt       = head.addr;
          write_data_nxt = head.wdata;
          wr_en_nxt      = !head.rnw;
          tmo_cnt_nxt    = '0;
          if (head.rnw) begin
            req_nxt     = 1'b0;
            lat_cnt_nxt = LAT_W'(READ_LATENCY);
            state_nxt   = READ_WAIT;
          end else if (head.addr == ADDR_WIDTH'(REQ_ADDR)) begin
            req_nxt   = 1'b1;
            state_nxt = WAIT_ACK;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        wr_en_nxt = 1'b0;
        state_nxt = IDLE;
      end
      WAIT_ACK: begin
        if (ack) begin
          req_nxt   = 1'b0;
          wr_en_nxt = 1'b0;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
          req_nxt   = 1'b0;
          wr_en_nxt = 1'b0;
          set_err   = 1'b1;
          state_nxt = IDLE;
        end else if (TIMEOUT != 0) begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      READ_WAIT: begin
        if (lat_cnt == '0) begin
          rsp_data_nxt  = read_data;
          rsp_valid_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A timeout in the same cycle as err_clr leaves the flag set.
    err_nxt = set_err ? 1'b1 : (err_clr ? 1'b0 : err);
  end

endmodule

// File: tb/tb_dbg_master.sv
// Bench for dbg_master: directed scenarios then random traffic, every output checked
// each cycle against a queue-and-deadline reference model.
module tb_dbg_master;

  localparam int unsigned AW   = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RL   = 2;
  localparam int unsigned REQ  = 0;
  localparam int unsigned TMO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          err;
  logic          err_clr;
  logic          busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic          wr_en;
  logic          req;
  logic [DW-1:0] read_data;
  logic          ack;

  always #5 clk = ~clk;

  dbg_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
    .READ_LATENCY(RL), .REQ_ADDR(REQ), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err(err), .err_clr(err_clr), .busy(busy),
    .addr(addr), .write_data(write_data), .wr_en(wr_en), .req(req),
    .read_data(read_data), .ack(ack)
  );

  typedef struct {
    bit          rnw;
    int unsigned a;
    logic [31:0] d;
  } cmd_s;

  // Reference model: pending commands plus the edge at which the active one ends.
  cmd_s        q[$];
  int          m_mode;   // 0 none, 1 plain write, 2 REQ write, 3 read
  longint      edge_no;
  longint      t_end;
  logic [31:0] e_addr, e_wdata, e_rsp_data;
  logic        e_wr_en, e_req, e_rsp_valid, e_err;

  int          n_chk, n_pass, n_fail;
  int          tgt_mode, tgt_delay, tgt_hold, tgt_cnt;
  bit          rd_force_en;
  logic [31:0] rd_force;

  function automatic void model_edge();
    bit   push_ok, rv_pre, set_err;
    cmd_s c;
    edge_no++;
    push_ok = (cmd_valid === 1'b1) && (q.size() < DEPTH);
    if (rst) begin
      q.delete();
      m_mode = 0;
      e_addr = '0; e_wdata = '0; e_rsp_data = '0;
      e_wr_en = 0; e_req = 0; e_rsp_valid = 0; e_err = 0;
      return;
    end
    rv_pre  = e_rsp_valid;
    set_err = 0;
    if (rv_pre && rsp_ready) e_rsp_valid = 0;
    case (m_mode)
      0: if (q.size() != 0 && !ack && !(q[0].rnw && rv_pre)) begin
           c = q.pop_front();
           e_addr  = c.a;
           e_wdata = c.d;
           e_wr_en = !c.rnw;
           if (c.rnw) begin
             m_mode = 3; t_end = edge_no + RL + 1;
           end else if (c.a == REQ) begin
             e_req = 1; m_mode = 2; t_end = edge_no + TMO;
           end else begin
             m_mode = 1; t_end = edge_no + 1;
           end
         end
      1: if (edge_no == t_end) begin e_wr_en = 0; m_mode = 0; end
      2: if (ack) begin
           e_req = 0; e_wr_en = 0; m_mode = 0;
         end else if (TMO != 0 && edge_no == t_end) begin
           e_req = 0; e_wr_en = 0; m_mode = 0; set_err = 1;
         end
      3: if (edge_no == t_end) begin
           e_rsp_data = read_data; e_rsp_valid = 1; m_mode = 0;
         end
      default: ;
    endcase
    if (set_err) e_err = 1;
    else if (err_clr) e_err = 0;
    if (push_ok) begin
      c.rnw = cmd_rnw; c.a = 32'(cmd_addr); c.d = cmd_wdata;
      q.push_back(c);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp_v, edge_no);
    end
  endtask

  task automatic check_all();
    chk("addr",       32'(addr),      e_addr);
    chk("write_data", write_data,     e_wdata);
    chk("wr_en",      32'(wr_en),     32'(e_wr_en));
    chk("req",        32'(req),       32'(e_req));
    chk("rsp_valid",  32'(rsp_valid), 32'(e_rsp_valid));
    chk("rsp_data",   rsp_data,       e_rsp_data);
    chk("err",        32'(err),       32'(e_err));
    chk("busy",       32'(busy),      32'((q.size() != 0) || (m_mode != 0)));
    chk("cmd_ready",  32'(cmd_ready), 32'(q.size() < DEPTH));
  endtask

  // Debug-target behaviour for the coming cycle: ack policy and read data.
  task automatic drive_target();
    read_data = $urandom();
    if (rd_force_en && m_mode == 3 && edge_no + 1 == t_end) read_data = rd_force;
    case (tgt_mode)
      1: begin
        if (ack) begin
          if (tgt_cnt == 0) begin ack = 1'b0; tgt_cnt = tgt_delay; end
          else tgt_cnt--;
        end else if (e_req) begin
          if (tgt_cnt == 0) begin ack = 1'b1; tgt_cnt = tgt_hold - 1; end
          else tgt_cnt--;
        end else begin
          tgt_cnt = tgt_delay;
        end
      end
      2:       ack = ($urandom_range(0, 3) == 0);
      default: ack = 1'b0;
    endcase
  endtask

  task automatic step();
    drive_target();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push_cmd(input bit rnw, input int unsigned a, input logic [31:0] d);
    bit acc;
    int k;
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = AW'(a); cmd_wdata = d;
    acc = 0; k = 0;
    do begin
      acc = (q.size() < DEPTH);
      step();
      k++;
    end while (!acc && k < 64);
    cmd_valid = 1'b0;
    if (!acc) begin
      n_chk++; n_fail++;
      $error("FAIL push_bound: observed not accepted expected accepted within 64 cycles");
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (((q.size() != 0) || (m_mode != 0)) && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) begin
      n_chk++; n_fail++;
      $error("FAIL idle_bound: observed busy expected idle within %0d cycles", bound);
    end
  endtask

  task automatic wait_timeout_edge();
    int k;
    k = 0;
    while (!(m_mode == 2 && edge_no + 1 == t_end && !ack) && k < 64) begin
      step();
      k++;
    end
    if (k >= 64) begin
      n_chk++; n_fail++;
      $error("FAIL timeout_bound: observed no timeout expected one within 64 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_chk = 0; n_pass = 0; n_fail = 0;
    edge_no = 0; t_end = 0; m_mode = 0;
    e_addr = '0; e_wdata = '0; e_rsp_data = '0;
    e_wr_en = 0; e_req = 0; e_rsp_valid = 0; e_err = 0;
    tgt_mode = 0; tgt_delay = 0; tgt_hold = 1; tgt_cnt = 0;
    rd_force_en = 0; rd_force = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; err_clr = 1'b0; read_data = '0; ack = 1'b0;

    // Reset state.
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Plain write: one-cycle wr_en, no req.
    push_cmd(0, 1, 32'hDEADBEEF);
    step();
    chk("w1_addr",  32'(addr), 32'd1);
    chk("w1_data",  write_data, 32'hDEADBEEF);
    chk("w1_wr_en", 32'(wr_en), 32'd1);
    chk("w1_req",   32'(req), 32'd0);
    step();
    chk("w1_wr_en_fall", 32'(wr_en), 32'd0);

    // REQ write with a slow target, then a second command behind it.
    tgt_mode = 1; tgt_delay = 5; tgt_hold = 2; tgt_cnt = 5;
    push_cmd(0, REQ, 32'h00000003);
    push_cmd(0, 1, 32'hA5A50001);
    wait_idle(100);
    chk("req_err_clear", 32'(err), 32'd0);

    // Reads: capture window and response back-pressure on a queued read.
    tgt_mode = 0; rd_force_en = 1; rd_force = 32'h12345678;
    push_cmd(1, 2, 32'h0);
    push_cmd(1, 3, 32'h0);
    repeat (RL + 6) step();
    chk("rd1_data",  rsp_data, 32'h12345678);
    chk("rd1_valid", 32'(rsp_valid), 32'd1);
    chk("rd2_held",  32'(busy), 32'd1);
    rd_force = 32'h0BADF00D;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    repeat (RL + 6) step();
    chk("rd2_data", rsp_data, 32'h0BADF00D);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    rd_force_en = 0;

    // Fill the FIFO behind a stalled REQ write.
    push_cmd(0, REQ, 32'h11111111);
    push_cmd(0, 1, 32'h22222222);
    push_cmd(0, 2, 32'h33333333);
    push_cmd(0, 3, 32'h44444444);
    push_cmd(0, 1, 32'h55555555);
    chk("fill_full", 32'(cmd_ready), 32'd0);
    push_cmd(0, 2, 32'h66666666);
    wait_idle(200);
    chk("fill_timeout_err", 32'(err), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);

    // Timeout colliding with err_clr: set wins.
    push_cmd(0, REQ, 32'h00000007);
    push_cmd(0, 3, 32'h77777777);
    wait_timeout_edge();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_set_wins", 32'(err), 32'd1);
    chk("tmo_req_fall", 32'(req), 32'd0);
    wait_idle(50);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Reset while waiting for ack with three commands queued.
    push_cmd(0, REQ, 32'h0000AAAA);
    push_cmd(0, 1, 32'h0000BBBB);
    push_cmd(0, 2, 32'h0000CCCC);
    push_cmd(0, 3, 32'h0000DDDD);
    chk("rst_pre_req", 32'(req), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_req",       32'(req), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_ready",     32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (10) step();
    chk("rst_no_issue", 32'(wr_en), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        tgt_mode  = $urandom_range(0, 2);
        tgt_delay = $urandom_range(0, 4);
        tgt_hold  = $urandom_range(1, 3);
        tgt_cnt   = tgt_delay;
      end
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_rnw   = ($urandom_range(0, 2) == 0);
      cmd_addr  = AW'($urandom_range(0, 3));
      cmd_wdata = $urandom();
      rsp_ready = ($urandom_range(0, 1) == 1);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    cmd_valid = 1'b0; rst = 1'b0; err_clr = 1'b0; rsp_ready = 1'b1; tgt_mode = 0;
    k = 0;
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
